// File: rtl/sample_stream_if.sv
// sample_stream_if: stream bundle around the error-matrix sampler.
//   rand_data  [63:0]  four 16-bit random samples, lane k in [16k+15:16k]
//   rand_valid         rand_data valid
//   rand_ready         sampler accepts a word when valid & ready
//   wr_en              write request to the error-matrix RAM
//   wr_ready           RAM accepts the write when wr_en & wr_ready
//   wr_addr    [11:0]  word address of the write
//   wr_data    [63:0]  four packed 16-bit mod-q samples
// The slave modport is the sampler; the master modport is its environment.
interface sample_stream_if;
   logic [63:0] rand_data;
   logic        rand_valid;
   logic        rand_ready;
   logic        wr_en;
   logic        wr_ready;
   logic [11:0] wr_addr;
   logic [63:0] wr_data;

   modport master (
      output rand_data, rand_valid, wr_ready,
      input  rand_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  rand_data, rand_valid, wr_ready,
      output rand_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/sample_stream.sv
// sample_stream: streaming FrodoKEM error-matrix sampler.
// Takes 64-bit random words, maps each 16-bit lane through the CDF-based error
// sampler of the latched security level, and writes packed results to the
// error-matrix RAM at incrementing addresses. One run yields one n x nbar matrix.
//   clk        clock
//   rst        asynchronous reset, active high
//   start      one-cycle pulse, begins a run (ignored unless idle)
//   sec_level  1, 3 or 5, sampled at start; other values act as level 1
//   bus        slave side of sample_stream_if (random input, RAM write output)
//   busy       high while a run is in progress
//   done       one-cycle pulse when the last write has been accepted
module sample_stream (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [2:0]             sec_level,
   sample_stream_if.slave         bus,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned Lanes   = 4;
   localparam int unsigned AddrW   = 12;
   localparam int unsigned Nbar    = 8;
   localparam int unsigned NL1     = 640;
   localparam int unsigned NL3     = 976;
   localparam int unsigned NL5     = 1344;
   localparam int unsigned TotalL1 = NL1 * Nbar / Lanes;
   localparam int unsigned TotalL3 = NL3 * Nbar / Lanes;
   localparam int unsigned TotalL5 = NL5 * Nbar / Lanes;

   // CDF tables without their final entry: only len-1 compares are made.
   localparam logic [14:0] CdfL1 [12] = '{15'd4643, 15'd13363, 15'd20579, 15'd25843,
                                          15'd29227, 15'd31145, 15'd32103, 15'd32525,
                                          15'd32689, 15'd32745, 15'd32762, 15'd32766};
   localparam logic [14:0] CdfL3 [10] = '{15'd5638, 15'd15915, 15'd23689, 15'd28571,
                                          15'd31116, 15'd32217, 15'd32613, 15'd32731,
                                          15'd32760, 15'd32766};
   localparam logic [14:0] CdfL5 [6]  = '{15'd9142, 15'd23462, 15'd30338, 15'd32361,
                                          15'd32725, 15'd32765};

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
   typedef enum logic [1:0] {LvL1, LvL3, LvL5} level_e;

   state_e            state_q, state_d;
   level_e            level_q, level_d;
   logic [AddrW-1:0]  in_cnt_q, in_cnt_d;
   logic [AddrW-1:0]  out_cnt_q, out_cnt_d;
   logic [63:0]       data_q, data_d;
   logic              wr_en_q, wr_en_d;
   logic [AddrW-1:0]  total;
   logic [63:0]       sampled;
   logic              accept;
   logic              wr_fire;

   // e counts CDF entries strictly below r[15:1]; r[0] negates mod q.
   function automatic logic [15:0] sample_lane(input logic [15:0] r, input level_e lvl);
      logic [14:0] t;
      logic [3:0]  e;
      logic [15:0] res;
      t = r[15:1];
      e = '0;
      case (lvl)
         LvL3:    for (int z = 0; z < 10; z++) e = e + {3'b000, (t > CdfL3[z])};
         LvL5:    for (int z = 0; z < 6; z++)  e = e + {3'b000, (t > CdfL5[z])};
         default: for (int z = 0; z < 12; z++) e = e + {3'b000, (t > CdfL1[z])};
      endcase
      res = r[0] ? (16'd0 - {12'd0, e}) : {12'd0, e};
      // q = 2^15 at level 1, so the reduction is just dropping bit 15.
      if (lvl == LvL1) res[15] = 1'b0;
      return res;
   endfunction

   always_comb begin
      sampled = '0;
      for (int unsigned k = 0; k < Lanes; k++) begin
         sampled[16*k +: 16] = sample_lane(bus.rand_data[16*k +: 16], level_q);
      end
   end

   always_comb begin
      case (level_q)
         LvL3:    total = AddrW'(TotalL3);
         LvL5:    total = AddrW'(TotalL5);
         default: total = AddrW'(TotalL1);
      endcase
   end

   // A new word may enter only if the output register is free or draining now.
   assign bus.rand_ready = (state_q == StRun) && (in_cnt_q < total) && (!wr_en_q || bus.wr_ready);
   assign accept         = bus.rand_valid && bus.rand_ready;
   assign wr_fire        = wr_en_q && bus.wr_ready;

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      data_d    = data_q;
      wr_en_d   = wr_en_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               case (sec_level)
                  3'd3:    level_d = LvL3;
                  3'd5:    level_d = LvL5;
                  default: level_d = LvL1;
               endcase
               in_cnt_d  = '0;
               out_cnt_d = '0;
               wr_en_d   = 1'b0;
               state_d   = StRun;
            end
         end
         StRun: begin
            if (wr_fire) begin
               out_cnt_d = out_cnt_q + AddrW'(1);
               wr_en_d   = 1'b0;
            end
            if (accept) begin
               data_d   = sampled;
               wr_en_d  = 1'b1;
               in_cnt_d = in_cnt_q + AddrW'(1);
               if (in_cnt_q == total - AddrW'(1)) state_d = StDrain;
            end
         end
         StDrain: begin
            if (wr_fire) begin
               out_cnt_d = out_cnt_q + AddrW'(1);
               wr_en_d   = 1'b0;
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         level_q   <= LvL1;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         data_q    <= '0;
         wr_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         data_q    <= data_d;
         wr_en_q   <= wr_en_d;
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = out_cnt_q;
   assign bus.wr_data = data_q;
   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);

endmodule

// File: tb/tb_sample_stream.sv
// tb_sample_stream: self-checking bench for sample_stream.
// Table of single-word vectors with hand-derived results, a negedge monitor
// with a scoreboard queue fed from an independent CDF model, and directed
// sequences for full runs, stalls, mid-run start and asynchronous abort.
module tb_sample_stream;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] sec_level = 3'd1;
   logic       busy;
   logic       done;

   sample_stream_if bus ();

   sample_stream dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sec_level (sec_level),
      .bus       (bus),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference sampler, written from the algorithm: full CDF tables, count entries below t.
   int cdf1 [13] = '{4643, 13363, 20579, 25843, 29227, 31145, 32103, 32525, 32689, 32745,
                     32762, 32766, 32767};
   int cdf3 [11] = '{5638, 15915, 23689, 28571, 31116, 32217, 32613, 32731, 32760, 32766, 32767};
   int cdf5 [7]  = '{9142, 23462, 30338, 32361, 32725, 32765, 32767};

   function automatic logic [15:0] ref_lane(input logic [15:0] r, input int lvl);
      int t, e, q, v;
      t = int'(r) / 2;
      e = 0;
      if (lvl == 3) begin
         q = 65536;
         for (int z = 0; z < 10; z++) if (t > cdf3[z]) e++;
      end else if (lvl == 5) begin
         q = 65536;
         for (int z = 0; z < 6; z++) if (t > cdf5[z]) e++;
      end else begin
         q = 32768;
         for (int z = 0; z < 12; z++) if (t > cdf1[z]) e++;
      end
      v = r[0] ? (q - e) % q : e;
      return v[15:0];
   endfunction

   function automatic logic [63:0] ref_word(input logic [63:0] w, input int lvl);
      logic [63:0] o;
      for (int k = 0; k < 4; k++) o[16*k +: 16] = ref_lane(w[16*k +: 16], lvl);
      return o;
   endfunction

   // Monitor / scoreboard, sampled on the falling edge.
   logic [63:0] sb [$];
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          mon_lvl = 1;
   int          exp_total = 1280;
   bit          stall_pending = 0;
   bit          fire_prev = 0;
   logic [11:0] held_addr;
   logic [63:0] held_data;

   always @(negedge clk) begin
      bit fire;
      fire = 0;
      if (rst) begin
         sb.delete();
         wr_cnt = 0;
         stall_pending = 0;
         fire_prev = 0;
      end else begin
         if (start && !busy) begin
            mon_lvl   = (sec_level == 3'd3) ? 3 : (sec_level == 3'd5) ? 5 : 1;
            exp_total = (mon_lvl == 3) ? 1952 : (mon_lvl == 5) ? 2688 : 1280;
            wr_cnt    = 0;
            sb.delete();
         end
         if (bus.rand_valid && bus.rand_ready) sb.push_back(ref_word(bus.rand_data, mon_lvl));
         if (stall_pending) begin
            check("hold_en", {79'd0, bus.wr_en}, 80'd1);
            check("hold_addr", {68'd0, bus.wr_addr}, {68'd0, held_addr});
            check("hold_data", {16'd0, bus.wr_data}, {16'd0, held_data});
         end
         stall_pending = 0;
         if (bus.wr_en) begin
            if (bus.wr_ready) begin
               fire = 1;
               check("wr_addr", {68'd0, bus.wr_addr}, 80'(wr_cnt));
               check("sb_nonempty", {79'd0, (sb.size() != 0)}, 80'd1);
               if (sb.size() != 0) check("wr_data", {16'd0, bus.wr_data}, {16'd0, sb.pop_front()});
               wr_cnt++;
            end else begin
               stall_pending = 1;
               held_addr = bus.wr_addr;
               held_data = bus.wr_data;
            end
         end
         if (done) begin
            done_cnt++;
            check("done_after_last_write", {79'd0, fire_prev}, 80'd1);
            check("write_count", 80'(wr_cnt), 80'(exp_total));
            check("sb_drained", 80'(sb.size()), 80'd0);
         end
         fire_prev = fire;
      end
   end

   task automatic apply_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic pulse_start(input logic [2:0] lvl);
      @(posedge clk);
      #1;
      sec_level = lvl;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Full run with random valid/ready duty cycles; optional start re-pulse mid-run.
   task automatic run(input logic [2:0] lvl, input int pv, input int pr, input int restart_at);
      int d0;
      int c;
      d0 = done_cnt;
      pulse_start(lvl);
      c = 0;
      while (done_cnt == d0 && c < 30000) begin
         bus.rand_valid = ($urandom_range(99) < pv);
         bus.rand_data  = {$urandom(), $urandom()};
         bus.wr_ready   = ($urandom_range(99) < pr);
         start          = (c == restart_at);
         @(posedge clk);
         #1;
         c++;
      end
      bus.rand_valid = 1'b0;
      bus.wr_ready   = 1'b0;
      start          = 1'b0;
      check("run_done_seen", 80'(done_cnt - d0), 80'd1);
      repeat (3) @(posedge clk);
      #1;
      check("done_single_pulse", 80'(done_cnt - d0), 80'd1);
      check("idle_after_done", {78'd0, busy, done}, 80'd0);
   endtask

   typedef struct {
      string       name;
      logic [2:0]  lvl;
      logic [63:0] rnd;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int c;
      int d0;
      bit got;

      vecs[0] = '{"l1_mixed",   3'd1, 64'hFFFF_2448_2446_0000, 64'h7FF4_0001_0000_0000};
      vecs[1] = '{"l5_all_ones", 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFA_FFFA_FFFA_FFFA};
      vecs[2] = '{"l3_all_ones", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFF6_FFF6_FFF6_FFF6};
      vecs[3] = '{"neg_zero",   3'd1, 64'h0001_0001_0001_0001, 64'h0000_0000_0000_0000};
      vecs[4] = '{"l5_edges",   3'd5, 64'hB74E_476F_476E_476C, 64'h0002_FFFF_0001_0000};
      vecs[5] = '{"l3_edges",   3'd3, 64'hFFF3_FFF2_2C0F_2C0E, 64'hFFF7_0009_FFFF_0001};
      vecs[6] = '{"l1_edges",   3'd1, 64'h246F_0003_FFFE_2446, 64'h7FFF_0000_000C_0000};
      vecs[7] = '{"level2_as_l1", 3'd2, 64'hFFFF_2448_2446_0000, 64'h7FF4_0001_0000_0000};

      bus.rand_data  = '0;
      bus.rand_valid = 1'b0;
      bus.wr_ready   = 1'b0;
      #12;
      check("reset_outputs", {bus.wr_en, bus.rand_ready, busy, done, bus.wr_addr, bus.wr_data},
            80'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single-word vectors: write stalls for two cycles, then is accepted.
      for (int i = 0; i < 8; i++) begin
         apply_reset();
         pulse_start(vecs[i].lvl);
         bus.rand_data  = vecs[i].rnd;
         bus.rand_valid = 1'b1;
         got = 0;
         c = 0;
         while (!got && c < 20) begin
            @(negedge clk);
            if (bus.rand_valid && bus.rand_ready) got = 1;
            c++;
         end
         check({vecs[i].name, "_accept"}, {79'd0, got}, 80'd1);
         @(posedge clk);
         #1;
         bus.rand_valid = 1'b0;
         bus.rand_data  = 64'h1234_5678_9ABC_DEF0;
         check({vecs[i].name, "_wr_en"}, {79'd0, bus.wr_en}, 80'd1);
         check({vecs[i].name, "_data"}, {16'd0, bus.wr_data}, {16'd0, vecs[i].exp});
         check({vecs[i].name, "_addr0"}, {68'd0, bus.wr_addr}, 80'd0);
         repeat (2) @(posedge clk);
         #1 bus.wr_ready = 1'b1;
         @(posedge clk);
         #1 bus.wr_ready = 1'b0;
         check({vecs[i].name, "_addr_next"}, {68'd0, bus.wr_addr}, 80'd1);
         check({vecs[i].name, "_wr_en_clr"}, {79'd0, bus.wr_en}, 80'd0);
      end
      apply_reset();

      // Full-throughput level-1 run.
      run(3'd1, 100, 100, -1);
      // Random stalls on both sides, level 3.
      run(3'd3, 60, 55, -1);
      // Level 5 with start re-pulsed mid-run.
      run(3'd5, 100, 100, 300);
      // Unsupported level behaves as level 1, with stalls.
      run(3'd2, 80, 70, -1);

      // Asynchronous abort around word 500, then a fresh run.
      d0 = done_cnt;
      pulse_start(3'd1);
      bus.rand_valid = 1'b1;
      bus.wr_ready   = 1'b1;
      c = 0;
      while (wr_cnt < 500 && c < 2000) begin
         @(posedge clk);
         #1 bus.rand_data = {$urandom(), $urandom()};
         c++;
      end
      check("reached_word_500", {79'd0, (wr_cnt >= 500)}, 80'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_outputs", {bus.wr_en, bus.rand_ready, busy, done, bus.wr_addr, bus.wr_data},
            80'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      bus.rand_valid = 1'b0;
      bus.wr_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("no_done_on_abort", 80'(done_cnt - d0), 80'd0);
      check("idle_after_abort", {79'd0, busy}, 80'd0);
      run(3'd1, 100, 100, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
